// File: rtl/store_buffer_if.sv
// Store buffer bus: pipeline store/load side plus RAM write port.
// The buffer sits on the slave modport and the pipeline on master.
interface store_buffer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  st_valid;
    logic [DATA_WIDTH-1:0] st_addr;
    logic [DATA_WIDTH-1:0] st_data;
    logic                  st_ready;
    logic [DATA_WIDTH-1:0] ld_addr;
    logic                  ld_hit;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  drain_stall;
    logic                  ram_we;
    logic [DATA_WIDTH-1:0] ram_w_addr;
    logic [DATA_WIDTH-1:0] ram_wd;
    logic                  empty;

    modport master (
        output st_valid, st_addr, st_data,
        output ld_addr, drain_stall,
        input  st_ready, ld_hit, ld_data,
        input  ram_we, ram_w_addr, ram_wd, empty
    );

    modport slave (
        input  st_valid, st_addr, st_data,
        input  ld_addr, drain_stall,
        output st_ready, ld_hit, ld_data,
        output ram_we, ram_w_addr, ram_wd, empty
    );
endinterface

// File: rtl/store_buffer.sv
// Store buffer: FIFO of pending word stores draining to the RAM
// write port, with youngest-match forwarding to the load in MEM.
module store_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    store_buffer_if.slave  bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef logic [DATA_WIDTH-1:0] word_t;

    word_t            addr_q [DEPTH];
    word_t            addr_d [DEPTH];
    word_t            data_q [DEPTH];
    word_t            data_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             not_empty;
    logic             enq;
    logic             deq;
    logic             fwd_hit;
    word_t            fwd_data;
    logic [PTR_W-1:0] fwd_idx;

    // Status and drain handshakes; st_ready sees only registered state.
    always_comb begin
        not_empty = (count_q != '0);
        enq       = bus.st_valid && (count_q != FULL);
        deq       = not_empty && !bus.drain_stall;
    end

    assign bus.st_ready   = (count_q != FULL);
    assign bus.empty      = !not_empty;
    assign bus.ram_we     = deq;
    assign bus.ram_w_addr = not_empty ? addr_q[head_q] : '0;
    assign bus.ram_wd     = not_empty ? data_q[head_q] : '0;
    assign bus.ld_hit     = fwd_hit;
    assign bus.ld_data    = fwd_data;

    // Walk valid entries oldest to youngest so the last match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PTR_W'(i);
            if ((CNT_W'(i) < count_q) &&
                (addr_q[fwd_idx] == bus.ld_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fwd_idx];
            end
        end
    end

    // Next-state: capture at tail, retire at head, track occupancy.
    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq) begin
            addr_d[tail_q] = bus.st_addr;
            data_d[tail_q] = bus.st_data;
            tail_d         = tail_q + 1'b1;
        end
        if (deq) begin
            head_d = head_q + 1'b1;
        end
        unique case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State registers; reset drops every pending store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: queue model checked every cycle plus
// directed scenarios with literal expectations.
module tb_store_buffer;
    localparam int DW = 32;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    ent_t q[$];
    ent_t wlog[$];

    store_buffer_if #(.DATA_WIDTH(DW)) sb ();

    store_buffer #(.DATA_WIDTH(DW), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Model: FIFO of pending stores, updated from sampled inputs.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
        end else begin
            bit dq;
            bit eq;
            dq = (q.size() != 0) && !sb.drain_stall;
            eq = sb.st_valid && (q.size() != 4);
            if (dq) void'(q.pop_front());
            if (eq) q.push_back({sb.st_addr, sb.st_data});
        end
    end

    // Record what the DUT actually writes to RAM.
    always @(posedge clk) begin
        if (rst_n && sb.ram_we) wlog.push_back({sb.ram_w_addr, sb.ram_wd});
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        int            n;
        logic          h;
        logic [DW-1:0] fd;
        n  = q.size();
        h  = 1'b0;
        fd = '0;
        for (int i = n - 1; i >= 0; i--) begin
            if (!h && q[i].a == sb.ld_addr) begin
                h  = 1'b1;
                fd = q[i].d;
            end
        end
        chk("st_ready", sb.st_ready, n != 4);
        chk("empty", sb.empty, n == 0);
        chk("ram_we", sb.ram_we, (n != 0) && !sb.drain_stall);
        chk("ram_w_addr", sb.ram_w_addr, (n != 0) ? q[0].a : '0);
        chk("ram_wd", sb.ram_wd, (n != 0) ? q[0].d : '0);
        chk("ld_hit", sb.ld_hit, h);
        chk("ld_data", sb.ld_data, fd);
    end

    task automatic next();
        @(posedge clk);
        #2;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    task automatic store(input logic [DW-1:0] a, input logic [DW-1:0] d);
        sb.st_valid = 1'b1;
        sb.st_addr  = a;
        sb.st_data  = d;
        next();
        sb.st_valid = 1'b0;
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rst_n          = 1'b0;
        sb.st_valid    = 1'b0;
        sb.st_addr     = '0;
        sb.st_data     = '0;
        sb.ld_addr     = '0;
        sb.drain_stall = 1'b0;
        next();
        mid();
        chk("rst st_ready", sb.st_ready, 1);
        chk("rst empty", sb.empty, 1);
        chk("rst ram_we", sb.ram_we, 0);
        chk("rst ld_hit", sb.ld_hit, 0);
        next();
        rst_n = 1'b1;

        // Single store, drained one cycle later.
        sb.st_valid = 1'b1;
        sb.st_addr  = 32'h10000;
        sb.st_data  = 32'hDEADBEEF;
        mid();
        chk("nobypass ram_we", sb.ram_we, 0);
        next();
        sb.st_valid = 1'b0;
        mid();
        chk("single ram_we", sb.ram_we, 1);
        chk("single addr", sb.ram_w_addr, 32'h10000);
        chk("single wd", sb.ram_wd, 32'hDEADBEEF);
        next();
        mid();
        chk("single empty", sb.empty, 1);
        next();

        // Fill to full, hold a fifth store, then release.
        wlog.delete();
        sb.drain_stall = 1'b1;
        for (int i = 0; i < 4; i++) store(32'h10000 + i, i + 1);
        sb.st_valid = 1'b1;
        sb.st_addr  = 32'h10004;
        sb.st_data  = 32'd5;
        mid();
        chk("full st_ready", sb.st_ready, 0);
        next();
        sb.drain_stall = 1'b0;
        mid();
        chk("full+drain st_ready", sb.st_ready, 0);
        chk("full+drain wd", sb.ram_wd, 1);
        next();
        mid();
        chk("freed st_ready", sb.st_ready, 1);
        next();
        sb.st_valid = 1'b0;
        repeat (6) next();
        chk("fill nwrites", wlog.size(), 5);
        for (int i = 0; i < wlog.size() && i < 5; i++)
            chk("fill order", wlog[i].d, i + 1);

        // Youngest-match forwarding.
        sb.drain_stall = 1'b1;
        store(32'h10004, 32'hA);
        store(32'h10008, 32'hB);
        store(32'h10004, 32'hC);
        sb.ld_addr = 32'h10004;
        mid();
        chk("fwd young hit", sb.ld_hit, 1);
        chk("fwd young data", sb.ld_data, 32'hC);
        next();
        sb.ld_addr = 32'h1000C;
        mid();
        chk("fwd miss hit", sb.ld_hit, 0);
        chk("fwd miss data", sb.ld_data, 0);
        next();
        sb.drain_stall = 1'b0;
        repeat (4) next();

        // Streaming across pointer wrap.
        wlog.delete();
        for (int k = 0; k < 10; k++) begin
            sb.st_valid = 1'b1;
            sb.st_addr  = 32'h10040 + k;
            sb.st_data  = 32'h100 + k;
            if (k > 0) begin
                sb.ld_addr = 32'h10040 + k - 1;
                mid();
                chk("wrap ld_hit", sb.ld_hit, 1);
                chk("wrap ld_data", sb.ld_data, 32'h100 + k - 1);
                chk("wrap st_ready", sb.st_ready, 1);
            end
            next();
        end
        sb.st_valid = 1'b0;
        repeat (3) next();
        chk("wrap nwrites", wlog.size(), 10);
        for (int i = 0; i < wlog.size() && i < 10; i++)
            chk("wrap order", wlog[i].a, 32'h10040 + i);

        // Entry draining this cycle still forwards.
        store(32'h10010, 32'h55);
        sb.ld_addr = 32'h10010;
        mid();
        chk("drainfwd ram_we", sb.ram_we, 1);
        chk("drainfwd hit", sb.ld_hit, 1);
        chk("drainfwd data", sb.ld_data, 32'h55);
        next();

        // Reset mid-run with three pending stores.
        sb.drain_stall = 1'b1;
        for (int i = 0; i < 3; i++) store(32'h10030 + i, 32'h30 + i);
        sb.ld_addr = 32'h10030;
        @(negedge clk);
        #3;
        sb.drain_stall = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst st_ready", sb.st_ready, 1);
        chk("midrst empty", sb.empty, 1);
        chk("midrst ram_we", sb.ram_we, 0);
        chk("midrst ld_hit", sb.ld_hit, 0);
        wlog.delete();
        next();
        rst_n = 1'b1;
        repeat (5) next();
        chk("midrst nwrites", wlog.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
